hiv1_assay_sequencer: RTL

Control-layer protocol sequencer that sits directly upstream of the HIV-1 p24 immunoassay flow netlist. It drives the select lines of switches flow_switch4_1, flow_switch4_2 and flow_switch3_1 and the pump enable, stepping the chip through block, sample, wash, conjugate, wash, substrate. Every step has a guard/run structure so that valves settle with the pump stopped. A timed abort flushes the path to the Control outlet.

---
 rtl/hiv1_assay_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hiv1_assay_sequencer.sv
// rtl/hiv1_assay_sequencer.sv - HIV-1 p24 assay valve/pump protocol sequencer
// Steps block/sample/wash/conjugate/wash/substrate, each as guard (pump off) then run (pump on).
module hiv1_assay_sequencer #(
  parameter int CNT_W    = 16,
  parameter int T_GUARD  = 4,
  parameter int T_BLOCK  = 100,
  parameter int T_SAMPLE = 100,
  parameter int T_WASH   = 100,
  parameter int T_CONJ   = 100,
  parameter int T_SUBST  = 100,
  parameter int T_FLUSH  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] sw4_1_sel,
  output logic [1:0] sw4_2_sel,
  output logic       sw3_sel,
  output logic       pump_en,
  output logic       busy,
  output logic [2:0] step,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [2:0] {IDLE, GUARD, RUN, AB_GUARD, AB_RUN} state_t;

  // Zero durations become one cycle, then truncate to the counter width.
  function automatic logic [CNT_W-1:0] dur(input int t);
    return CNT_W'((t == 0) ? 1 : t);
  endfunction

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] G_LD = dur(T_GUARD) - ONE;
  localparam logic [CNT_W-1:0] B_LD = dur(T_BLOCK) - ONE;
  localparam logic [CNT_W-1:0] S_LD = dur(T_SAMPLE) - ONE;
  localparam logic [CNT_W-1:0] W_LD = dur(T_WASH) - ONE;
  localparam logic [CNT_W-1:0] C_LD = dur(T_CONJ) - ONE;
  localparam logic [CNT_W-1:0] U_LD = dur(T_SUBST) - ONE;
  localparam logic [CNT_W-1:0] F_LD = dur(T_FLUSH) - ONE;

  // {sw4_2_sel, sw4_1_sel} per protocol step
  function automatic logic [3:0] sel_of(input logic [2:0] s);
    case (s)
      3'd0:    return {2'd0, 2'd2};
      3'd1:    return {2'd3, 2'd2};
      3'd3:    return {2'd1, 2'd0};
      3'd5:    return {2'd1, 2'd3};
      default: return {2'd1, 2'd2};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] run_ld(input logic [2:0] s);
    case (s)
      3'd0:    return B_LD;
      3'd1:    return S_LD;
      3'd3:    return C_LD;
      3'd5:    return U_LD;
      default: return W_LD;
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // step doubles as the protocol position while in GUARD/RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= 3'd7;
      sw4_2_sel <= 2'd1;
      sw4_1_sel <= 2'd2;
      sw3_sel   <= 1'b1;
      pump_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                  <= GUARD;
            step                   <= 3'd0;
            busy                   <= 1'b1;
            cnt                    <= G_LD;
            {sw4_2_sel, sw4_1_sel} <= sel_of(3'd0);
            sw3_sel                <= 1'b0;
          end
        end
        GUARD, RUN: begin
          if (abort) begin
            state     <= AB_GUARD;
            step      <= 3'd6;
            cnt       <= G_LD;
            sw4_2_sel <= 2'd1;
            sw4_1_sel <= 2'd2;
            sw3_sel   <= 1'b1;
            pump_en   <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (state == GUARD) begin
            state   <= RUN;
            pump_en <= 1'b1;
            cnt     <= run_ld(step);
          end else if (step != 3'd5) begin
            state                  <= GUARD;
            pump_en                <= 1'b0;
            step                   <= step + 3'd1;
            cnt                    <= G_LD;
            {sw4_2_sel, sw4_1_sel} <= sel_of(step + 3'd1);
          end else begin
            state     <= IDLE;
            step      <= 3'd7;
            sw4_2_sel <= 2'd1;
            sw4_1_sel <= 2'd2;
            sw3_sel   <= 1'b1;
            pump_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        AB_GUARD: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state   <= AB_RUN;
            pump_en <= 1'b1;
            cnt     <= F_LD;
          end
        end
        AB_RUN: begin
          // Abort selects already match the idle selects; only pump/busy/step change.
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state   <= IDLE;
            step    <= 3'd7;
            pump_en <= 1'b0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
